// File: rtl/packed_delay_line.sv
// rtl/packed_delay_line.sv - programmable multi-channel clock-cycle delay line
//
// Carries a packed record of NUM_CH fields (CH_W bits each, ch0 in the LSBs)
// through a circular buffer so that a record sampled with in_valid=1 at edge k
// appears on out_valid/out_data after edge k+dly_q. The delay is programmable
// at run time (1..MAX_DLY); reprogramming flushes everything in flight.
//
// Optional feature macro: PDL_OCCUPANCY_EN (adds inflight/ovf_err outputs).
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   cfg_load   in   1   pulse: load cfg_dly and flush the buffer
//   cfg_dly    in   AW  requested delay in cycles
//   in_valid   in   1   in_data valid this cycle
//   in_data    in   DW  packed input record
//   out_valid  out  1   out_data valid (registered)
//   out_data   out  DW  delayed record, holds when out_valid=0 (registered)
//   busy       out  1   high while refilling after reset or flush
//   dly_err    out  1   one-cycle pulse when cfg_dly is rejected
//   inflight   out  AW  valid records in the buffer (PDL_OCCUPANCY_EN only)
//   ovf_err    out  1   sticky occupancy overflow (PDL_OCCUPANCY_EN only)

module packed_delay_line #(
    parameter  int NUM_CH  = 3,
    parameter  int CH_W    = 1,
    parameter  int MAX_DLY = 32,
    parameter  int DLY_RST = 25,
    localparam int DW      = NUM_CH * CH_W,
    localparam int AW      = $clog2(MAX_DLY + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_load,
    input  logic [AW-1:0] cfg_dly,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          dly_err
`ifdef PDL_OCCUPANCY_EN
    ,
    output logic [AW-1:0] inflight,
    output logic          ovf_err
`endif
);

    localparam int            IW       = $clog2(MAX_DLY);
    localparam logic [AW:0]   MAX_E    = (AW+1)'(MAX_DLY);
    localparam logic [AW-1:0] MAX_A    = AW'(MAX_DLY);
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_DLY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

    state_t        r_state;
    logic [AW-1:0] r_dly;
    logic [AW-1:0] r_cnt;
    logic [IW-1:0] r_wptr;          // slot written most recently
    logic [MAX_DLY-1:0] r_vld;
    logic [DW-1:0] r_mem [MAX_DLY];
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_busy;
    logic          r_dly_err;

    logic          w_cfg_ok;
    logic          w_flush;
    logic          w_bad;
    logic [IW-1:0] w_widx;
    logic [AW:0]   w_rsum;
    logic [IW-1:0] w_ridx;
    logic          w_fill_done;
    logic          w_run_nxt;
    logic          w_out_fire;

    assign w_cfg_ok = (cfg_dly != '0) && (cfg_dly <= MAX_A);
    assign w_flush  = cfg_load & w_cfg_ok;
    assign w_bad    = cfg_load & ~w_cfg_ok;

    // Write slot is one past r_wptr, so read index (wptr - dly + 1) mod MAX_DLY
    // is the slot written dly edges ago. At dly=MAX_DLY read and write share a
    // slot and the read sees the old contents, which is exactly the oldest record.
    assign w_widx = (r_wptr == LAST_IDX) ? '0 : r_wptr + IW'(1);
    assign w_rsum = {{(AW+1-IW){1'b0}}, r_wptr} + MAX_E + (AW+1)'(1) - {1'b0, r_dly};
    assign w_ridx = (w_rsum >= MAX_E) ? IW'(w_rsum - MAX_E) : IW'(w_rsum);

    assign w_fill_done = (r_state == ST_FILL) && (r_cnt == r_dly - AW'(1));
    // Output is gated by the state being entered, so the first record after a
    // refill is not lost on the edge where FILL hands over to RUN.
    assign w_run_nxt   = !w_flush && ((r_state == ST_RUN) || w_fill_done);
    assign w_out_fire  = r_vld[w_ridx] & w_run_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_vld  <= '0;
        end else begin
            r_wptr <= w_widx;
            if (w_flush) begin
                r_vld <= '0;                    // flush wins over same-cycle input
            end else begin
                r_vld[w_widx] <= in_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && !w_flush) begin
            r_mem[w_widx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dly       <= AW'(DLY_RST);
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_dly_err   <= 1'b0;
        end else begin
            r_dly_err   <= w_bad;
            r_out_valid <= w_out_fire;
            if (w_out_fire) begin
                r_out_data <= r_mem[w_ridx];
            end
            if (w_flush) begin
                r_dly <= cfg_dly;
            end
            r_busy <= w_flush || (r_state == ST_IDLE) ||
                      ((r_state == ST_FILL) && !w_fill_done);
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FILL;
                    r_cnt   <= '0;
                end
                ST_FILL: begin
                    if (w_flush) begin
                        r_cnt <= '0;
                    end else if (w_fill_done) begin
                        r_state <= ST_RUN;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                ST_RUN: begin
                    if (w_flush) begin
                        r_state <= ST_FILL;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign dly_err   = r_dly_err;

`ifdef PDL_OCCUPANCY_EN
    logic [AW-1:0] r_inflight;
    logic          r_ovf;
    logic          w_acc;

    assign w_acc = in_valid & ~w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_ovf      <= 1'b0;
        end else if (w_flush) begin
            r_inflight <= '0;
        end else begin
            case ({w_acc, w_out_fire})
                2'b10: begin
                    if (r_inflight >= MAX_A) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_inflight <= r_inflight + AW'(1);
                    end
                end
                2'b01: begin
                    if (r_inflight != '0) begin
                        r_inflight <= r_inflight - AW'(1);
                    end
                end
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign inflight = r_inflight;
    assign ovf_err  = r_ovf;
`endif

endmodule

// File: tb/tb_packed_delay_line.sv
// tb/tb_packed_delay_line.sv - directed self-checking bench for packed_delay_line

module tb_packed_delay_line;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_load;
    logic [5:0] cfg_dly;
    logic       in_valid;
    logic [2:0] in_data;
    logic       out_valid;
    logic [2:0] out_data;
    logic       busy;
    logic       dly_err;
`ifdef PDL_OCCUPANCY_EN
    logic [5:0] inflight;
    logic       ovf_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    packed_delay_line #(
        .NUM_CH (3),
        .CH_W   (1),
        .MAX_DLY(32),
        .DLY_RST(25)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_load (cfg_load),
        .cfg_dly  (cfg_dly),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .busy     (busy),
        .dly_err  (dly_err)
`ifdef PDL_OCCUPANCY_EN
        ,
        .inflight (inflight),
        .ovf_err  (ovf_err)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_load = 1'b0; cfg_dly = 6'd0; in_valid = 1'b0; in_data = 3'd0;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 3'd0) begin n_bad++; $display("FAIL rst_out_data got %b want 000", out_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (dly_err !== 1'b0) begin n_bad++; $display("FAIL rst_dly_err got %b want 0", dly_err); end
`ifdef PDL_OCCUPANCY_EN
        n_cmp++; if (inflight !== 6'd0) begin n_bad++; $display("FAIL rst_inflight got %0d want 0", inflight); end
`endif
    endtask

    task automatic test_initial_delay();
        logic ev;
        rst_n = 1'b1; in_valid = 1'b1; in_data = 3'b101;
        for (int e = 0; e <= 30; e++) begin
            tick();
            if (e == 0) begin in_valid = 1'b0; in_data = 3'd0; end
            ev = (e == 25);
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL init_valid edge=%0d got %b want %b", e, out_valid, ev); end
            n_cmp++; if (busy !== (e <= 24)) begin n_bad++; $display("FAIL init_busy edge=%0d got %b want %b", e, busy, (e <= 24)); end
            if (e >= 25) begin
                n_cmp++; if (out_data !== 3'b101) begin n_bad++; $display("FAIL init_data edge=%0d got %b want 101", e, out_data); end
            end
        end
    endtask

    task automatic test_dly1();
        logic ev;
        cfg_load = 1'b1; cfg_dly = 6'd1; in_valid = 1'b1; in_data = 3'b111;
        tick();
        cfg_load = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL d1_flush_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL d1_flush_busy got %b want 1", busy); end
        for (int j = 0; j <= 9; j++) begin
            in_valid = (j < 8);
            in_data  = (j < 8) ? 3'(j) : 3'd0;
            tick();
            ev = (j >= 1) && (j <= 8);
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL d1_valid j=%0d got %b want %b", j, out_valid, ev); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL d1_busy j=%0d got %b want 0", j, busy); end
            if (j >= 1) begin
                n_cmp++;
                if (out_data !== 3'((j >= 9) ? 7 : j - 1)) begin
                    n_bad++; $display("FAIL d1_data j=%0d got %0d want %0d", j, out_data, (j >= 9) ? 7 : j - 1);
                end
            end
        end
    endtask

    task automatic test_max_dly();
        logic ev;
        int   s;
        cfg_load = 1'b1; cfg_dly = 6'd32; in_valid = 1'b0; in_data = 3'd0;
        tick();
        cfg_load = 1'b0;
        for (int j = 0; j < 136; j++) begin
            in_valid = (j < 100) && (j % 7 != 3);
            in_data  = (j < 100) ? 3'((j * 5 + 3) % 8) : 3'd0;
            tick();
            s  = j - 32;
            ev = (s >= 0) && (s < 100) && (s % 7 != 3);
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL max_valid j=%0d got %b want %b", j, out_valid, ev); end
            if (ev) begin
                n_cmp++;
                if (out_data !== 3'((s * 5 + 3) % 8)) begin
                    n_bad++; $display("FAIL max_data j=%0d got %0d want %0d", j, out_data, (s * 5 + 3) % 8);
                end
            end
            n_cmp++; if (busy !== (j < 31)) begin n_bad++; $display("FAIL max_busy j=%0d got %b want %b", j, busy, (j < 31)); end
        end
    endtask

    task automatic test_bad_cfg();
        logic ev;
        for (int k = 0; k <= 35; k++) begin
            in_valid = (k == 0);
            in_data  = (k == 0) ? 3'b110 : 3'd0;
            cfg_load = (k == 1) || (k == 2);
            cfg_dly  = (k == 1) ? 6'd0 : 6'd40;
            tick();
            ev = (k == 1) || (k == 2);
            n_cmp++; if (dly_err !== ev) begin n_bad++; $display("FAIL bad_err k=%0d got %b want %b", k, dly_err, ev); end
            ev = (k == 32);
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL bad_valid k=%0d got %b want %b", k, out_valid, ev); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_busy k=%0d got %b want 0", k, busy); end
            if (k == 32) begin
                n_cmp++; if (out_data !== 3'b110) begin n_bad++; $display("FAIL bad_data got %b want 110", out_data); end
            end
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_flush_mid();
        logic       ev;
        logic [2:0] ed;
        int         s;
        for (int k = 0; k <= 54; k++) begin
            cfg_load = (k == 40);
            cfg_dly  = 6'd4;
            in_valid = (k <= 48);
            in_data  = (k < 40) ? 3'(k * 3 + 1) : (k == 40) ? 3'b010 : 3'(k);
            tick();
            if (k < 40) begin
                ev = (k >= 32);
                ed = 3'((k - 32) * 3 + 1);
            end else if (k <= 44) begin
                ev = 1'b0;
                ed = 3'd0;
            end else begin
                s  = k - 4;
                ev = (s >= 41) && (s <= 48);
                ed = 3'(s);
            end
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL fl_valid k=%0d got %b want %b", k, out_valid, ev); end
            if (ev) begin
                n_cmp++; if (out_data !== ed) begin n_bad++; $display("FAIL fl_data k=%0d got %0d want %0d", k, out_data, ed); end
            end
            n_cmp++;
            if (busy !== ((k >= 40) && (k <= 43))) begin
                n_bad++; $display("FAIL fl_busy k=%0d got %b want %b", k, busy, ((k >= 40) && (k <= 43)));
            end
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = 3'(k + 2);
            tick();
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rm_pre_valid got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 3'd7) begin n_bad++; $display("FAIL rm_pre_data got %0d want 7", out_data); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 3'd0) begin n_bad++; $display("FAIL rm_data got %0d want 0", out_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy got %b want 0", busy); end
`ifdef PDL_OCCUPANCY_EN
        n_cmp++; if (inflight !== 6'd0) begin n_bad++; $display("FAIL rm_inflight got %0d want 0", inflight); end
`endif
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_held_valid got %b want 0", out_valid); end
        rst_n = 1'b1; in_valid = 1'b0; in_data = 3'd0;
        for (int e = 0; e <= 26; e++) begin
            tick();
            n_cmp++; if (busy !== (e <= 24)) begin n_bad++; $display("FAIL rm_busy edge=%0d got %b want %b", e, busy, (e <= 24)); end
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_after_valid edge=%0d got %b want 0", e, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_initial_delay();
        test_dly1();
        test_max_dly();
        test_bad_cfg();
        test_flush_mid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
